// File: rtl/font5_trim_pkg.sv
// font5_trim_pkg: shared widths and FSM state encoding for the trim DAC controller
package font5_trim_pkg;
  localparam int TRIM_WORD_W = 16;
  localparam int TRIM_ADDR_W = 4;
  localparam int TRIM_VAL_W  = 12;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, LOAD, GAP} trim_state_t;
endpackage

// File: rtl/trim_shift.sv
// trim_shift: 16-bit MSB-first shift register, bit counter and SCK half-period timer
module trim_shift
  import font5_trim_pkg::*;
#(
  parameter int SCK_HALF = 2
) (
  input  logic                   clk40,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   run,
  input  logic                   fall,
  input  logic                   step,
  input  logic [TRIM_WORD_W-1:0] word,
  output logic                   sdi,
  output logic                   last,
  output logic                   half_end
);
  logic [TRIM_WORD_W-1:0] sr;
  logic [3:0] cnt;
  logic [3:0] tmr;
  assign sdi      = sr[TRIM_WORD_W-1];
  assign last     = cnt == 4'd0;
  assign half_end = tmr == 4'(SCK_HALF - 1);
  // timer restarts on every phase boundary; data advances on the falling sck edge, bit count after each low phase
  always_ff @(posedge clk40 or negedge rst_n)
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
      tmr <= '0;
    end else begin
      tmr <= (load || !run || half_end) ? 4'd0 : tmr + 4'd1;
      sr  <= load ? word : fall ? {sr[TRIM_WORD_W-2:0], 1'b0} : sr;
      cnt <= load ? 4'd15 : (step && !last) ? cnt - 4'd1 : cnt;
    end
endmodule

// File: rtl/trim_dac_ctrl.sv
// trim_dac_ctrl: round-robin host/auto arbiter driving a serial trim DAC; TRIM_SHADOW_EN adds a 16x12 readback shadow
module trim_dac_ctrl
  import font5_trim_pkg::*;
#(
  parameter int SCK_HALF = 2,
  parameter int GAP_CYC  = 2
) (
  input  logic                   clk40,
  input  logic                   rst_n,
  input  logic                   host_req,
  input  logic [TRIM_ADDR_W-1:0] host_addr,
  input  logic [TRIM_VAL_W-1:0]  host_val,
  output logic                   host_ack,
  input  logic                   auto_req,
  input  logic [TRIM_ADDR_W-1:0] auto_addr,
  input  logic [TRIM_VAL_W-1:0]  auto_val,
  output logic                   auto_ack,
  output logic                   busy,
  output logic                   done,
  output logic                   trim_cs_ld,
  output logic                   trim_sck,
  output logic                   trim_sdi,
  input  logic [TRIM_ADDR_W-1:0] rd_addr,
  output logic [TRIM_VAL_W-1:0]  rd_data
);
  trim_state_t state;
  logic last_auto;
  logic grant_host;
  logic load;
  logic half_end;
  logic last;
  logic [3:0] gap_cnt;
  assign grant_host = host_req && (!auto_req || last_auto);
  assign load       = (state == IDLE) && (host_req || auto_req);
  trim_shift #(.SCK_HALF(SCK_HALF)) u_shift (
    .clk40    (clk40),
    .rst_n    (rst_n),
    .load     (load),
    .run      (state inside {SETUP, SHIFT_HI, SHIFT_LO}),
    .fall     (state == SHIFT_HI && half_end),
    .step     (state == SHIFT_LO && half_end),
    .word     (grant_host ? {host_addr, host_val} : {auto_addr, auto_val}),
    .sdi      (trim_sdi),
    .last     (last),
    .half_end (half_end)
  );
  // transfer sequencer with registered serial-port, handshake and status outputs
  always_ff @(posedge clk40 or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      trim_cs_ld <= 1'b1;
      trim_sck   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      host_ack   <= 1'b0;
      auto_ack   <= 1'b0;
      last_auto  <= 1'b1;
      gap_cnt    <= '0;
    end else begin
      host_ack <= 1'b0;
      auto_ack <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (load) begin
          state      <= SETUP;
          trim_cs_ld <= 1'b0;
          busy       <= 1'b1;
          host_ack   <= grant_host;
          auto_ack   <= !grant_host;
          last_auto  <= !grant_host;
        end
        SETUP: if (half_end) begin
          state    <= SHIFT_HI;
          trim_sck <= 1'b1;
        end
        SHIFT_HI: if (half_end) begin
          state    <= SHIFT_LO;
          trim_sck <= 1'b0;
        end
        SHIFT_LO: if (half_end) begin
          state      <= last ? LOAD : SHIFT_HI;
          trim_sck   <= !last;
          trim_cs_ld <= last;
          done       <= last;
        end
        LOAD: begin
          state   <= GAP;
          gap_cnt <= '0;
        end
        GAP: if (gap_cnt == 4'(GAP_CYC - 1)) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else gap_cnt <= gap_cnt + 4'd1;
        default: state <= IDLE;
      endcase
    end
`ifdef TRIM_SHADOW_EN
  logic [TRIM_ADDR_W-1:0] wr_addr;
  logic [TRIM_VAL_W-1:0]  wr_val;
  logic [TRIM_VAL_W-1:0]  shadow [16];
  // remember the granted channel/value until the word is committed in LOAD
  always_ff @(posedge clk40 or negedge rst_n)
    if (!rst_n) begin
      wr_addr <= '0;
      wr_val  <= '0;
    end else if (load) begin
      wr_addr <= grant_host ? host_addr : auto_addr;
      wr_val  <= grant_host ? host_val : auto_val;
    end
  // shadow mirrors only words that completed; an aborted word never reaches LOAD
  always_ff @(posedge clk40 or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 16; i++) shadow[i] <= '0;
    else if (state == LOAD) shadow[wr_addr] <= wr_val;
  assign rd_data = shadow[rd_addr];
`else
  logic unused_rd;
  assign unused_rd = ^rd_addr;
  assign rd_data   = '0;
`endif
endmodule

// File: tb/tb_trim_dac_ctrl.sv
// tb_trim_dac_ctrl: directed self-checking bench for trim_dac_ctrl (default and SCK_HALF=1/GAP_CYC=1 instances)
module tb_trim_dac_ctrl;
  logic clk40 = 1'b0;
  logic rst_n = 1'b0;
  logic host_req = 1'b0, auto_req = 1'b0;
  logic [3:0] host_addr = '0, auto_addr = '0, rd_addr = '0;
  logic [11:0] host_val = '0, auto_val = '0;
  logic host_ack, auto_ack, busy, done, trim_cs_ld, trim_sck, trim_sdi;
  logic [11:0] rd_data;
  logic h1_req = 1'b0;
  logic [3:0] h1_addr = '0;
  logic [11:0] h1_val = '0;
  logic h1_ack, a1_ack, busy1, done1, cs1, sck1, sdi1;
  logic [11:0] rd1;
  int checks = 0, errors = 0;

  always #5 clk40 = ~clk40;

  trim_dac_ctrl dut (
    .clk40(clk40), .rst_n(rst_n),
    .host_req(host_req), .host_addr(host_addr), .host_val(host_val), .host_ack(host_ack),
    .auto_req(auto_req), .auto_addr(auto_addr), .auto_val(auto_val), .auto_ack(auto_ack),
    .busy(busy), .done(done), .trim_cs_ld(trim_cs_ld), .trim_sck(trim_sck), .trim_sdi(trim_sdi),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  trim_dac_ctrl #(.SCK_HALF(1), .GAP_CYC(1)) dut1 (
    .clk40(clk40), .rst_n(rst_n),
    .host_req(h1_req), .host_addr(h1_addr), .host_val(h1_val), .host_ack(h1_ack),
    .auto_req(1'b0), .auto_addr(4'd0), .auto_val(12'd0), .auto_ack(a1_ack),
    .busy(busy1), .done(done1), .trim_cs_ld(cs1), .trim_sck(sck1), .trim_sdi(sdi1),
    .rd_addr(4'd0), .rd_data(rd1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] sh = '0, wsh [32];
  int wlow [32], whigh [32];
  int n_words = 0, n_falls = 0, n_done = 0, nb = 0, run_low = 0, run_high = 0;
  logic pcs = 1'b1, psck = 1'b0;
  always @(negedge clk40) begin
    if (!rst_n) begin
      pcs = 1'b1; psck = 1'b0; run_low = 0; run_high = 0; nb = 0;
    end else begin
      if (trim_sck && !psck) begin sh = {sh[14:0], trim_sdi}; nb++; end
      if (!trim_cs_ld) run_low++; else run_high++;
      if (trim_cs_ld && !pcs) begin
        if (n_words < 32) begin wsh[n_words] = sh; wlow[n_words] = run_low; end
        n_words++; run_low = 0; nb = 0;
      end
      if (!trim_cs_ld && pcs) begin
        if (n_falls < 32) whigh[n_falls] = run_high;
        n_falls++; run_high = 0;
      end
      if (done) n_done++;
      pcs = trim_cs_ld; psck = trim_sck;
    end
  end

  logic [15:0] sh1 = '0;
  int low1 = 0, run1 = 0, n1 = 0, n1_done = 0, per1 = 0, since1 = 0;
  logic p1cs = 1'b1, p1sck = 1'b0;
  always @(negedge clk40) begin
    if (!rst_n) begin
      p1cs = 1'b1; p1sck = 1'b0; run1 = 0; since1 = 0;
    end else begin
      since1++;
      if (sck1 && !p1sck) begin sh1 = {sh1[14:0], sdi1}; per1 = since1; since1 = 0; end
      if (!cs1) run1++;
      if (cs1 && !p1cs) begin low1 = run1; run1 = 0; n1++; end
      if (done1) n1_done++;
      p1cs = cs1; p1sck = sck1;
    end
  end

  int host_left = 0, auto_left = 0, host_acks = 0, auto_acks = 0, n_grants = 0;
  bit order [32];

  task automatic serve(input int budget);
    int t = 0;
    bit hd, ad;
    while ((host_req || auto_req || busy) && t < budget) begin
      @(negedge clk40);
      hd = host_ack; ad = auto_ack;
      if (hd) begin host_acks++; if (n_grants < 32) order[n_grants] = 1'b0; n_grants++; end
      if (ad) begin auto_acks++; if (n_grants < 32) order[n_grants] = 1'b1; n_grants++; end
      @(posedge clk40); #1;
      if (hd) begin host_left--; if (host_left <= 0) host_req = 1'b0; else host_val = host_val + 12'd1; end
      if (ad) begin auto_left--; if (auto_left <= 0) auto_req = 1'b0; else auto_val = auto_val + 12'd1; end
      t++;
    end
    check("serve_timeout", 32'(t < budget), 1);
  endtask

  initial begin
    int t, w0, f0, d0, g0, a0;
    bit seen;
    repeat (2) @(negedge clk40);
    check("rst_cs_ld", trim_cs_ld, 1);
    check("rst_sck", trim_sck, 0);
    check("rst_sdi", trim_sdi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_auto_ack", auto_ack, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(posedge clk40); #1;

    w0 = n_words; f0 = n_falls; d0 = n_done; g0 = n_grants;
    host_addr = 4'd1; host_val = 12'h111; auto_addr = 4'd2; auto_val = 12'h222;
    host_left = 1; auto_left = 1; host_req = 1'b1; auto_req = 1'b1;
    serve(400);
    check("tie1_first_host", 32'(order[g0]), 0);
    check("tie1_second_auto", 32'(order[g0+1]), 1);
    check("tie1_word0", wsh[w0], 16'h1111);
    check("tie1_word1", wsh[w0+1], 16'h2222);
    check("tie1_gap", whigh[f0+1], 4);
    check("tie1_done", n_done - d0, 2);

    w0 = n_words; d0 = n_done; a0 = host_acks;
    host_addr = 4'd3; host_val = 12'hA5C; host_left = 1; host_req = 1'b1;
    serve(200);
    check("host_word", wsh[w0], 16'h3A5C);
    check("host_low", wlow[w0], 66);
    check("host_ack_cnt", host_acks - a0, 1);
    check("host_done", n_done - d0, 1);

    w0 = n_words; g0 = n_grants;
    host_addr = 4'd4; host_val = 12'h444; auto_addr = 4'd6; auto_val = 12'h666;
    host_left = 1; auto_left = 1; host_req = 1'b1; auto_req = 1'b1;
    serve(400);
    check("tie2_first_auto", 32'(order[g0]), 1);
    check("tie2_second_host", 32'(order[g0+1]), 0);
    check("tie2_word0", wsh[w0], 16'h6666);
    check("tie2_word1", wsh[w0+1], 16'h4444);

    w0 = n_words; f0 = n_falls; d0 = n_done; a0 = auto_acks;
    auto_addr = 4'd7; auto_val = 12'h100; auto_left = 3; auto_req = 1'b1;
    serve(600);
    check("b2b_acks", auto_acks - a0, 3);
    check("b2b_done", n_done - d0, 3);
    for (int k = 0; k < 3; k++) begin
      check("b2b_word", wsh[w0+k], 32'h7100 + 32'(k));
      check("b2b_low", wlow[w0+k], 66);
    end
    check("b2b_gap1", whigh[f0+1], 4);
    check("b2b_gap2", whigh[f0+2], 4);

    w0 = n_words; d0 = n_done;
    host_addr = 4'd5; host_val = 12'h123; host_req = 1'b1; seen = 1'b0; t = 0;
    while (nb != 9 && t < 300) begin
      @(negedge clk40);
      if (host_ack) seen = 1'b1;
      else if (seen) host_req = 1'b0;
      t++;
    end
    check("rst_bit7_timeout", 32'(t < 300), 1);
    host_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs_ld", trim_cs_ld, 1);
    check("mid_rst_sck", trim_sck, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk40);
    rst_n = 1'b1;
    rd_addr = 4'd5;
    @(posedge clk40); #1;
    check("mid_rst_no_done", n_done - d0, 0);
    check("mid_rst_no_word", n_words - w0, 0);
    check("mid_rst_shadow", rd_data, 0);

    w0 = n_words; d0 = n_done;
    host_addr = 4'd5; host_val = 12'h123; host_left = 1; host_req = 1'b1;
    serve(200);
    check("rereq_word", wsh[w0], 16'h5123);
    check("rereq_low", wlow[w0], 66);
    check("rereq_done", n_done - d0, 1);

    host_addr = 4'd9; host_val = 12'h7FF; host_left = 1; host_req = 1'b1;
    serve(200);
    rd_addr = 4'd9; #1;
`ifdef TRIM_SHADOW_EN
    check("shadow_9", rd_data, 12'h7FF);
    rd_addr = 4'd5; #1;
    check("shadow_5", rd_data, 12'h123);
`else
    check("shadow_9_off", rd_data, 0);
    rd_addr = 4'd5; #1;
    check("shadow_5_off", rd_data, 0);
`endif

    @(posedge clk40); #1;
    h1_addr = 4'd3; h1_val = 12'hA5C; h1_req = 1'b1; seen = 1'b0; t = 0; w0 = n1;
    while (n1 == w0 && t < 200) begin
      @(negedge clk40);
      if (h1_ack) seen = 1'b1;
      else if (seen) h1_req = 1'b0;
      t++;
    end
    check("p_timeout", 32'(t < 200), 1);
    check("p_low", low1, 33);
    check("p_sck_period", per1, 2);
    check("p_word", sh1, 16'h3A5C);
    repeat (3) @(negedge clk40);
    check("p_busy_idle", busy1, 0);
    check("p_done", n1_done, 1);
    check("p_auto_ack", a1_ack, 0);
    check("p_rd", rd1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
